// File: rtl/nf_pwm_fader_pkg.sv
// -----------------------------------------------------------------------------
// nf_pwm_fader_pkg
// Shared constants for the PWM fader: register offsets (addr[3:2] values),
// CTRL bit positions and the fade controller state encoding.
// -----------------------------------------------------------------------------
package nf_pwm_fader_pkg;

   // Register offsets as seen on addr[3:2]
   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_TARGET = 2'd1;
   localparam logic [1:0] REG_STEP   = 2'd2;
   localparam logic [1:0] REG_PERIOD = 2'd3;

   // CTRL register bit positions
   localparam int CTRL_RUN_BIT     = 0;
   localparam int CTRL_IRQ_CLR_BIT = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_STEP = 2'd2,
      ST_DONE = 2'd3
   } fade_state_e;

endpackage

// File: rtl/nf_fade_tmr.sv
// -----------------------------------------------------------------------------
// nf_fade_tmr
// Step-period down-counter for the PWM fader.
//   clk      : system clock
//   rst      : synchronous active-high reset, counter -> 0
//   load     : load counter with load_val (wins over en)
//   load_val : reload value
//   en       : decrement by one (saturates at 0)
//   zero     : counter is at 0 or 1, i.e. the wait expires this cycle
// -----------------------------------------------------------------------------
module nf_fade_tmr #(
   parameter int PER_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [PER_W-1:0] load_val,
   input  logic             en,
   output logic             zero
);

   logic [PER_W-1:0] cnt_q;
   logic [PER_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - PER_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Treating 1 like 0 makes a loaded PERIOD of 0 behave as 1.
   assign zero = (cnt_q <= PER_W'(1));

endmodule

// File: rtl/nf_pwm_fader.sv
// -----------------------------------------------------------------------------
// nf_pwm_fader
// Register-programmed PWM brightness fader. Walks the PWM compare value 'cur'
// toward TARGET by STEP once every PERIOD+1 cycles, writing each new value to
// the PWM, and raises a sticky irq when the target is reached.
//   clk    : system clock
//   resetn : synchronous reset, ACTIVE-HIGH despite the name
//   addr   : CPU address, only addr[3:2] decoded
//   we     : CPU write strobe
//   wd     : CPU write data
//   rd     : CPU read data, combinational from addr
//   pwm_we : one-cycle write strobe to the PWM compare register
//   pwm_wd : compare value for the PWM (zero-extended, 0 when pwm_we=0)
//   irq    : sticky fade-done flag
// -----------------------------------------------------------------------------
module nf_pwm_fader
   import nf_pwm_fader_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int PER_W = 24
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        pwm_we,
   output logic [31:0] pwm_wd,
   output logic        irq
);

   fade_state_e      state_q, state_d;
   logic [CNT_W-1:0] cur_q, cur_d;
   logic [CNT_W-1:0] target_q, target_d;
   logic [CNT_W-1:0] step_q, step_d;
   logic [PER_W-1:0] period_q, period_d;
   logic             run_q, run_d;
   logic             irq_q, irq_d;

   logic             tmr_load;
   logic             tmr_en;
   logic             tmr_zero;
   logic             ctrl_wr;
   logic             busy;
   logic [CNT_W-1:0] step_val;
   logic             unused_ok;

   // Move cur toward tgt by stp (0 treated as 1), clamped so it never
   // overshoots the target or wraps.
   function automatic logic [CNT_W-1:0] step_toward(
      input logic [CNT_W-1:0] cur,
      input logic [CNT_W-1:0] tgt,
      input logic [CNT_W-1:0] stp
   );
      logic [CNT_W-1:0] s;
      logic [CNT_W-1:0] diff;
      s = (stp == '0) ? CNT_W'(1) : stp;
      if (cur < tgt) begin
         diff = tgt - cur;
         step_toward = (diff <= s) ? tgt : cur + s;
      end else begin
         diff = cur - tgt;
         step_toward = (diff <= s) ? tgt : cur - s;
      end
   endfunction

   assign ctrl_wr   = we && (addr[3:2] == REG_CTRL);
   assign busy      = (state_q != ST_IDLE);
   assign step_val  = step_toward(cur_q, target_q, step_q);
   assign unused_ok = ^{addr[31:4], addr[1:0], wd};

   nf_fade_tmr #(
      .PER_W (PER_W)
   ) u_tmr (
      .clk      (clk),
      .rst      (resetn),
      .load     (tmr_load),
      .load_val (period_q),
      .en       (tmr_en),
      .zero     (tmr_zero)
   );

   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      target_d = target_q;
      step_d   = step_q;
      period_d = period_q;
      run_d    = run_q;
      irq_d    = irq_q;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
      pwm_we   = 1'b0;

      if (we) begin
         case (addr[3:2])
            REG_TARGET: target_d = wd[CNT_W-1:0];
            REG_STEP:   step_d   = wd[CNT_W-1:0];
            REG_PERIOD: period_d = wd[PER_W-1:0];
            default:    ;
         endcase
      end

      case (state_q)
         ST_WAIT: begin
            tmr_en = 1'b1;
            if (tmr_zero) begin
               state_d = ST_STEP;
            end
         end
         ST_STEP: begin
            pwm_we = 1'b1;
            cur_d  = step_val;
            if (step_val == target_q) begin
               state_d = ST_DONE;
            end else begin
               state_d  = ST_WAIT;
               tmr_load = 1'b1;
            end
         end
         ST_DONE: begin
            run_d   = 1'b0;
            state_d = ST_IDLE;
         end
         default: ;
      endcase

      // A CTRL write overrides whatever the FSM was about to do, including a
      // pending STEP: cur is held and no PWM write goes out.
      if (ctrl_wr) begin
         pwm_we   = 1'b0;
         cur_d    = cur_q;
         tmr_en   = 1'b0;
         tmr_load = 1'b0;
         run_d    = wd[CTRL_RUN_BIT];
         if (wd[CTRL_IRQ_CLR_BIT]) begin
            irq_d = 1'b0;
         end
         if (wd[CTRL_RUN_BIT]) begin
            if ((state_q == ST_IDLE) && (target_q == cur_q)) begin
               state_d = ST_DONE;
            end else begin
               state_d  = ST_WAIT;
               tmr_load = 1'b1;
            end
         end else begin
            state_d = ST_IDLE;
         end
      end

      // irq is raised on entry to DONE so it is visible during the DONE cycle;
      // holding the set through DONE makes set win over a same-cycle irq_clr.
      if ((state_d == ST_DONE) || (state_q == ST_DONE)) begin
         irq_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         state_q  <= ST_IDLE;
         cur_q    <= '0;
         target_q <= '0;
         step_q   <= CNT_W'(1);
         period_q <= '0;
         run_q    <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cur_q    <= cur_d;
         target_q <= target_d;
         step_q   <= step_d;
         period_q <= period_d;
         run_q    <= run_d;
         irq_q    <= irq_d;
      end
   end

   assign pwm_wd = pwm_we ? 32'(step_val) : 32'd0;
   assign irq    = irq_q;

   always_comb begin
      rd = 32'd0;
      case (addr[3:2])
         REG_CTRL:   rd = {16'(cur_q), 13'b0, busy, irq_q, run_q};
         REG_TARGET: rd = 32'(target_q);
         REG_STEP:   rd = 32'(step_q);
         REG_PERIOD: rd = 32'(period_q);
         default:    rd = 32'd0;
      endcase
   end

endmodule
